// File: rtl/piso_tx8_pkg.sv
// Shared definitions for the piso_tx8 serialiser: FSM state encoding and
// lane-mode constants.
package piso_tx8_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  localparam logic MODE_SINGLE = 1'b0;
  localparam logic MODE_DOUBLE = 1'b1;

endpackage

// File: rtl/piso_tx8_shift.sv
// Shift datapath for piso_tx8: parallel load, then right shift by one or two
// bits per beat with zero fill at the MSB end. Holds when neither load nor
// shift is asserted.
module tx_shift_reg
  import piso_tx8_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic             dbl_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] sr_o
);

  logic [WIDTH-1:0] sr_q;
  logic [WIDTH-1:0] sr_d;

  // Load wins over shift so a zero-gap reload on the final beat starts clean.
  always_comb begin
    sr_d = sr_q;
    if (load_i) begin
      sr_d = din_i;
    end else if (shift_i) begin
      if (dbl_i == MODE_DOUBLE) sr_d = sr_q >> 2;
      else                      sr_d = sr_q >> 1;
    end
  end

  // Register update with synchronous clear.
  always_ff @(posedge clk) begin
    if (rst_i) sr_q <= '0;
    else       sr_q <= sr_d;
  end

  assign sr_o = sr_q;

endmodule

// File: rtl/piso_tx8.sv
// Parallel-in serial-out transmitter. Accepts a WIDTH-bit word on a
// valid/ready handshake and emits it LSB first, one or two bits per beat.
//
// state | meaning
// IDLE  | no frame in progress, ready for a word
// SHIFT | frame in progress, one beat presented per enabled cycle
module piso_tx8
  import piso_tx8_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             Re,
  input  logic             en,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] din,
  input  logic             dbl,
  output logic [1:0]       sOut,
  output logic             sValid,
  output logic             last,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH) + 1;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            dbl_q, dbl_d;
  logic [WIDTH-1:0] sr;

  logic in_shift;
  logic final_beat;
  logic accept;
  logic do_shift;

  assign in_shift   = (state_q == SHIFT);
  assign final_beat = in_shift && (cnt_q == CW'(1));
  assign load_ready = (state_q == IDLE) || (final_beat && en);
  // A word offered while reset is asserted must not be taken.
  assign accept     = load_valid && load_ready && !Re;
  assign do_shift   = in_shift && en;

  // Next-state, beat counter and lane-mode latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dbl_d   = dbl_q;
    if (accept) begin
      state_d = SHIFT;
      dbl_d   = dbl;
      cnt_d   = (dbl == MODE_DOUBLE) ? CW'(WIDTH / 2) : CW'(WIDTH);
    end else if (do_shift) begin
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) state_d = IDLE;
    end
  end

  // Control registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (Re) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dbl_q   <= MODE_SINGLE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dbl_q   <= dbl_d;
    end
  end

  tx_shift_reg #(.WIDTH(WIDTH)) u_shift (
    .clk     (clk),
    .rst_i   (Re),
    .load_i  (accept),
    .shift_i (do_shift),
    .dbl_i   (dbl_q),
    .din_i   (din),
    .sr_o    (sr)
  );

  assign sValid = in_shift;
  assign busy   = in_shift;
  assign last   = final_beat;
  assign sOut   = in_shift ? {((dbl_q == MODE_DOUBLE) ? sr[1] : 1'b0), sr[0]} : 2'b00;

endmodule

// File: doc/piso_tx8.md
PISO_TX8 -- requirements
Module: piso_tx8

Interface
REQ-001 SHALL have parameter WIDTH, default 8, frame width in bits; even, >= 2.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port Re  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port en  input  1  shift enable; 0 = hold all state.
REQ-005 SHALL have port load_valid  input  1  parallel word offered.
REQ-006 SHALL have port load_ready  output  1  transmitter accepts word this cycle.
REQ-007 SHALL have port din  input  WIDTH  parallel word, LSB transmitted first.
REQ-008 SHALL have port dbl  input  1  lane mode sampled at load: 0 = 1 bit/beat, 1 = 2 bits/beat.
REQ-009 SHALL have port sOut  output  2  serial lanes; sOut[0] = next bit, sOut[1] = following bit (dbl only).
REQ-010 SHALL have port sValid  output  1  sOut carries a valid beat.
REQ-011 SHALL have port last  output  1  current beat is final beat of frame.
REQ-012 SHALL have port busy  output  1  frame in progress.

Function
REQ-013 SHALL implement states IDLE and SHIFT.
REQ-014 SHALL drive load_ready = 1 in IDLE, and in SHIFT only on the final beat with en = 1.
REQ-015 SHALL accept a word at an edge where load_valid && load_ready: capture din into shift register, latch dbl, set beat counter to WIDTH (dbl=0) or WIDTH/2 (dbl=1), enter or stay in SHIFT.
REQ-016 SHALL present the first beat in the cycle immediately after the accepting edge (latency 1).
REQ-017 In SHIFT, sValid = 1, busy = 1, sOut[0] = sr[0], sOut[1] = latched dbl ? sr[1] : 0.
REQ-018 In SHIFT with en = 1, each edge SHALL shift sr right by 1 (dbl=0) or 2 (dbl=1), zero-filling at MSB, and decrement counter by 1.
REQ-019 In SHIFT with en = 0, sr, counter, state SHALL hold; sOut, sValid, last SHALL remain stable; no load accepted.
REQ-020 last SHALL be 1 only in SHIFT when counter == 1.
REQ-021 After the final beat with en = 1 and no accepted load, SHALL return to IDLE; with accepted load, SHALL begin the next frame with zero gap.
REQ-022 In IDLE, sOut = 0, sValid = 0, last = 0, busy = 0; en is ignored.
REQ-023 dbl and din SHALL be ignored on cycles without an accepted load.
REQ-024 A frame SHALL always be WIDTH bits; no partial frames.

Reset
REQ-025 Re = 1 at a rising edge SHALL force IDLE, sr = 0, counter = 0, latched dbl = 0, regardless of state (including mid-frame, which aborts the frame).
REQ-026 Re SHALL take priority over load and en in the same cycle; load_valid during reset is not accepted.
REQ-027 In the cycle after reset: load_ready = 1, sValid = 0, last = 0, busy = 0, sOut = 0.

Structure
REQ-028 The shared package SHALL hold the state enum (IDLE, SHIFT) and lane-mode constants (MODE_SINGLE = 0, MODE_DOUBLE = 1).
REQ-029 Shift datapath SHALL be a sub-module tx_shift_reg (load, shift-by-1/2, hold); FSM and counter stay in piso_tx8.
REQ-030 Counter width SHALL be $clog2(WIDTH)+1 bits; no wrap below 0 reachable.

Verification
REQ-031 Single: load 0xA5, dbl=0, en=1 -> sOut[0] = 1,0,1,0,0,1,0,1 over 8 cycles, sOut[1] = 0, last on 8th beat only, IDLE after.
REQ-032 Double: load 0xC6, dbl=1 -> sOut[1:0] = 2'b10, 2'b01, 2'b00, 2'b11 over 4 cycles, last on 4th.
REQ-033 Back-to-back: load_valid held high with 0x0F then 0xF0, dbl=0 -> 16 contiguous beats, sValid never drops, last on beats 8 and 16.
REQ-034 Stall: load 0x81, dbl=0, en=0 for 3 cycles after beat 2 -> beat-2 value (0) held 4 cycles total, remaining sequence unchanged, frame ends 3 cycles later.
REQ-035 Reset mid-frame: load 0xFF, Re=1 at beat 3 with load_valid=1 -> next cycle IDLE, sValid = 0, sOut = 0, no word accepted; following load of 0x01 transmits cleanly.
